// File: rtl/mul_pipe_unit.sv
// Three-stage RISC-V M-extension multiply execute unit (MUL/MULH/MULHSU/MULHU).
// Operands are reduced to magnitudes, multiplied unsigned, then the sign is reapplied.

module Wallace_multiplier_64 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sign,
  output logic [63:0] product
);

  localparam int ROWS = 34;

  logic [63:0] rows [ROWS];

  // Rows 32/33 subtract the weight of the operand sign bits when sign=1.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      rows[i] = b[i] ? ({32'd0, a} << i) : 64'd0;
    end
    rows[32] = (sign && a[31]) ? (64'd0 - {b, 32'd0}) : 64'd0;
    rows[33] = (sign && b[31]) ? (64'd0 - {a, 32'd0}) : 64'd0;
  end

  // Carry-save reduction: groups of three rows collapse to two per level.
  always_comb begin
    logic [63:0] w  [ROWS];
    logic [63:0] nw [ROWS];
    int n;
    int m;
    int k;
    for (int i = 0; i < ROWS; i++) begin
      w[i]  = rows[i];
      nw[i] = 64'd0;
    end
    n = ROWS;
    m = 0;
    k = 0;
    for (int lvl = 0; lvl < 9; lvl++) begin
      if (n > 2) begin
        for (int i = 0; i < ROWS; i++) begin
          nw[i] = 64'd0;
        end
        m = 0;
        for (int g = 0; g < 12; g++) begin
          if (3 * g + 2 < n) begin
            nw[m]     = w[3*g] ^ w[3*g+1] ^ w[3*g+2];
            nw[m + 1] = ((w[3*g] & w[3*g+1]) | (w[3*g] & w[3*g+2]) |
                         (w[3*g+1] & w[3*g+2])) << 1;
            m = m + 2;
          end
        end
        k = (n / 3) * 3;
        for (int i = 0; i < ROWS; i++) begin
          if (i >= k && i < n) begin
            nw[m] = w[i];
            m = m + 1;
          end
        end
        for (int i = 0; i < ROWS; i++) begin
          w[i] = nw[i];
        end
        n = m;
      end
    end
    product = w[0] + w[1];
  end

endmodule

module mul_pipe_unit #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int DATA_W = 32;
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  // 0x80000000 negates to itself, which is already the correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                  input logic is_signed);
    if (is_signed && v[DATA_W-1]) return $unsigned(-v);
    return $unsigned(v);
  endfunction

  function automatic logic [DATA_W-1:0] sign_select(input logic [2*DATA_W-1:0] prod,
                                                    input logic neg,
                                                    input logic [1:0] op);
    logic signed [2*DATA_W-1:0] s;
    s = neg ? -$signed(prod) : $signed(prod);
    if (op == OP_MUL) return s[DATA_W-1:0];
    return s[2*DATA_W-1:DATA_W];
  endfunction

  logic signed [DATA_W-1:0] rs1_s, rs2_s;
  logic                     sgn1, sgn2, neg_c;
  logic                     adv, accept;

  logic                     vld_p0, vld_p1, vld_p2;
  logic [1:0]               op_p0, op_p1;
  logic                     neg_p0, neg_p1;
  logic [TAG_W-1:0]         tag_p0, tag_p1, tag_p2;
  logic [DATA_W-1:0]        mag1_p0, mag2_p0;
  logic [2*DATA_W-1:0]      prod_c, prod_p1;
  logic [DATA_W-1:0]        res_p2;

  assign rs1_s  = in_rs1;
  assign rs2_s  = in_rs2;
  assign sgn1   = (in_op != OP_MULHU);
  assign sgn2   = (in_op == OP_MUL) || (in_op == OP_MULH);
  assign neg_c  = (rs1_s[DATA_W-1] & sgn1) ^ (rs2_s[DATA_W-1] & sgn2);

  assign adv    = !vld_p2 || out_ready;
  assign accept = in_valid && adv && !flush;

  assign in_ready   = adv;
  assign out_valid  = vld_p2;
  assign out_result = res_p2;
  assign out_tag    = tag_p2;
  assign busy       = vld_p0 | vld_p1 | vld_p2;

  Wallace_multiplier_64 u_mul (
    .a       (mag1_p0),
    .b       (mag2_p0),
    .sign    (1'b0),
    .product (prod_c)
  );

  // Valid bits and the visible output word; flush wins over accept and out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      res_p2 <= '0;
      tag_p2 <= '0;
    end else begin
      if (flush) begin
        vld_p0 <= 1'b0;
        vld_p1 <= 1'b0;
        vld_p2 <= 1'b0;
      end else if (adv) begin
        vld_p0 <= accept;
        vld_p1 <= vld_p0;
        vld_p2 <= vld_p1;
      end
      // S1 -> S2: reapply sign and pick the word
      if (adv && vld_p1) begin
        res_p2 <= sign_select(prod_p1, neg_p1, op_p1);
        tag_p2 <= tag_p1;
      end
    end
  end

  // S0 capture and S0 -> S1 product register
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0   <= in_op;
      neg_p0  <= neg_c;
      tag_p0  <= in_tag;
      mag1_p0 <= magnitude(rs1_s, sgn1);
      mag2_p0 <= magnitude(rs2_s, sgn2);
    end
    if (adv && vld_p0) begin
      op_p1   <= op_p0;
      neg_p1  <= neg_p0;
      tag_p1  <= tag_p0;
      prod_p1 <= prod_c;
    end
  end

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (vld_p2 && !out_ready && !flush) |=> (vld_p2 && $stable(res_p2) && $stable(tag_p2)));

  a_flush: assert property (@(posedge clk) disable iff (!rst_n)
    flush |=> !busy);

endmodule

// File: tb/tb_mul_pipe_unit.sv
// Scoreboard bench for mul_pipe_unit: driver pushes expected results, monitor pops on handshake.

module tb_mul_pipe_unit;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_rs1, in_rs2;
  logic [4:0]  in_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        busy;

  exp_t        sb[$];
  int          total  = 0;
  int          passed = 0;
  logic        hold_prev = 1'b0;
  logic [31:0] prev_res;
  logic [4:0]  prev_tag;
  logic        rand_done = 1'b0;

  mul_pipe_unit #(.TAG_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_tag     (in_tag),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: full-precision signed/unsigned products, then word select.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb_, ub, p;
    logic [63:0] u;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    ub  = longint'({32'd0, b});
    u   = {32'd0, a} * {32'd0, b};
    case (op)
      2'b00: begin p = sa * sb_; return p[31:0]; end
      2'b01: begin p = sa * sb_; return p[63:32]; end
      2'b10: begin p = sa * ub;  return p[63:32]; end
      default: return u[63:32];
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_prev) begin
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_result", {32'd0, out_result}, {32'd0, prev_res});
        chk("hold_tag", {59'd0, out_tag}, {59'd0, prev_tag});
      end
      if (out_valid && !out_ready) chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      if (out_valid && out_ready && !flush) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", {63'd0, out_valid}, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", {32'd0, out_result}, {32'd0, e.res});
          chk("tag", {59'd0, out_tag}, {59'd0, e.tag});
        end
      end
      hold_prev = out_valid && !out_ready && !flush;
      prev_res  = out_result;
      prev_tag  = out_tag;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp);
    logic acc;
    exp_t e;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_rs1   = a;
    in_rs2   = b;
    in_tag   = tag;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      acc = in_ready && !flush;
      if (acc) begin
        e.res = exp;
        e.tag = tag;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) chk("issue_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int t = 0; t < 100; t++) begin
      if (sb.size() == 0 && !busy) break;
      @(posedge clk);
      #1;
    end
    chk("drain_queue", 64'(sb.size()), 64'd0);
    chk("drain_busy", {63'd0, busy}, 64'd0);
  endtask

  task automatic latency3(input string name);
    chk({name, "_e1"}, {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    chk({name, "_e2"}, {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    chk({name, "_e3"}, {63'd0, out_valid}, 64'd1);
  endtask

  initial begin
    logic [31:0] specials [6];
    specials[0] = 32'h8000_0000;
    specials[1] = 32'hFFFF_FFFF;
    specials[2] = 32'h0000_0000;
    specials[3] = 32'h7FFF_FFFF;
    specials[4] = 32'h0000_0001;
    specials[5] = 32'h8000_0001;

    rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_rs1 = '0; in_rs2 = '0;
    in_tag = '0; flush = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_out_result", {32'd0, out_result}, 64'd0);
    chk("rst_out_tag", {59'd0, out_tag}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    issue(2'b00, 32'd7, 32'd6, 5'h0A, 32'h0000_002A);
    latency3("mul_lat");
    drain();

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h01, 32'h0000_0000);
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, 5'h02, 32'h4000_0000);
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h03, 32'hFFFF_FFFE);
    issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h04, 32'hFFFF_FFFF);
    issue(2'b00, 32'h8000_0000, 32'h0000_0001, 5'h05, 32'h8000_0000);
    issue(2'b01, 32'h0000_0000, 32'hFFFF_FFFB, 5'h06, 32'h0000_0000);
    issue(2'b00, 32'h0000_0000, 32'hFFFF_FFFB, 5'h07, 32'h0000_0000);
    drain();

    fork
      begin
        issue(2'b00, 32'd100, 32'hFFFF_FFFD, 5'h11, 32'hFFFF_FED4);
        issue(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 5'h12, model(2'b11, 32'h1234_5678, 32'h9ABC_DEF0));
        issue(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'h13, model(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D));
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'h14, model(2'b10, 32'h8000_0000, 32'hFFFF_FFFF));
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    issue(2'b00, 32'd1, 32'd2, 5'h15, 32'd2);
    issue(2'b00, 32'd3, 32'd4, 5'h16, 32'd12);
    issue(2'b00, 32'd5, 32'd6, 5'h17, 32'd30);
    in_valid = 1'b1; in_op = 2'b11; in_rs1 = 32'd9; in_rs2 = 32'd9; in_tag = 5'h18;
    flush = 1'b1;
    @(negedge clk) sb.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_busy", {63'd0, busy}, 64'd0);
    issue(2'b00, 32'd11, 32'd13, 5'h19, 32'd143);
    latency3("post_flush_lat");
    drain();

    issue(2'b00, 32'd21, 32'd2, 5'h1A, 32'd42);
    issue(2'b11, 32'd21, 32'd3, 5'h1B, 32'd0);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_no_stale", {63'd0, out_valid}, 64'd0);
    issue(2'b00, 32'd3, 32'hFFFF_FFFE, 5'h1C, 32'hFFFF_FFFA);
    drain();

    fork
      begin
        for (int n = 0; n < 300; n++) begin
          logic [1:0]  op;
          logic [31:0] a, b;
          op = 2'($urandom_range(0, 3));
          a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
          b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
          issue(op, a, b, 5'($urandom_range(0, 31)), model(op, a, b));
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
